alu_iter_exec: RTL and testbench
================================

Name: alu_iter_exec

Overview:
- Execute-stage ALU that consumes the 4-bit Operation code from the ALU controller, together with the two operands.
- Produces a registered result and a branch-taken flag.
- Logic ops, add/sub, compare and branch ops complete in 1 cycle.
- Shifts use an iterative shifter, which holds the pipeline via busy.

Parameters:
- DATA_W, 32: operand/result width.
- SHIFT_STEP, 1: bit positions shifted per cycle in SHIFT state. Must be a power of 2 and no larger than DATA_W.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  launch an operation; sampled only in IDLE
- operation  in  4  ALU operation code (encoding below)
- src_a  in  DATA_W  operand A (rs1)
- src_b  in  DATA_W  operand B (rs2 or immediate); shift amount is src_b[$clog2(DATA_W)-1:0]
- busy  out  1  high while an operation is in flight (SHIFT state); upstream stalls on it
- done  out  1  one-cycle pulse when result/branch_taken become valid
- result  out  DATA_W  registered result, held until the next done
- branch_taken  out  1  registered branch decision, held until the next done

Behaviour:
- Operation encoding:
  - AND 0000, OR 0001, XOR 0011, SLL 0100, SRL 0101.
  - SUB 1010, ADD 1011, SLT 1100.
  - BEQ 1000, BNE 1101, BLT 1110, BGE 1111.
  - All other codes are illegal.
- Reset: state=IDLE; busy=0, done=0, result=0, branch_taken=0; shift register and counter cleared.
- IDLE, start=0: done=0; result and branch_taken hold.
- IDLE, start=1, non-shift op:
  - result/branch_taken registered at the next edge; done=1 for that one cycle (latency 1); stays in IDLE.
- Arithmetic: ADD/SUB wrap modulo 2^DATA_W. SLT = signed(src_a) < signed(src_b), zero-extended to DATA_W.
- Branch ops:
  - result=0.
  - BEQ: branch_taken = (a==b). BNE: (a!=b). BLT: signed a<b. BGE: signed a>=b.
  - All non-branch ops drive branch_taken=0.
- Illegal code: result=0, branch_taken=0, done after 1 cycle.
- IDLE, start=1, SLL/SRL:
  - Latch src_a into the shift register and shamt into the remaining-count counter; latch direction.
  - shamt==0: behaves as a 1-cycle op; result=src_a; no SHIFT state entered.
  - Otherwise, next state SHIFT, busy=1.
- SHIFT, each cycle:
  - Shift by min(SHIFT_STEP, remaining): SLL shifts left, SRL shifts right logical, zero fill. Decrement remaining by the same amount.
  - When remaining reaches 0: result=shift register, done=1, busy=0, back to IDLE.
  - Total latency = ceil(shamt/SHIFT_STEP)+1 cycles from start to done.
- start, operation and operands are ignored while busy; the in-flight operation is unaffected.
- start asserted in the same cycle that done pulses, while in IDLE: accepted as a new op (back-to-back ops at 1/cycle).
- reset mid-shift: abort; IDLE and all outputs 0 on the next edge; no done pulse.
- busy is combinational from state (state==SHIFT); done is a registered pulse.

Decomposition:
- Shared package alu_pkg:
  - Operation code localparams: OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SUB, OP_ADD, OP_SLT, OP_BEQ, OP_BNE, OP_BLT, OP_BGE.
  - typedef enum logic [0:0] {IDLE, SHIFT} exec_state_t.
  - The ALU controller imports the same constants.
- One sub-module, alu_iter_shifter: shift register, remaining counter, step logic, and a last-step flag.
- The top level contains the FSM, the combinational single-cycle datapath, and the output registers.

Test Plan:
- Reset held 2 cycles with start=1 -> busy=0, done=0, result=0, branch_taken=0 throughout.
- start, ADD, a=0x7FFFFFFF, b=1 -> next cycle done=1, result=0x80000000.
- Follow with SUB back-to-back, a=0, b=1 -> next cycle done=1, result=0xFFFFFFFF.
- SLT a=0xFFFFFFFF, b=1 -> result=1.
- BLT same operands -> result=0, branch_taken=1.
- BGE a=5, b=5 -> branch_taken=1.
- BNE a=5, b=5 -> branch_taken=0.
- SHIFT_STEP=1: SLL a=0x00000001, shamt=31 -> busy high 31 cycles, done on cycle 32, result=0x80000000.
- SRL a=0x80000000, shamt=0 -> done after 1 cycle, result=0x80000000, busy never high.
- SHIFT_STEP=4: SRL a=0xF0000000, shamt=5 -> done 3 cycles after start, result=0x07800000.
- A new start with ADD during the shift -> ignored.
- SLL a=0xFF, shamt=8, reset asserted on 3rd busy cycle -> next cycle busy=0, result=0, no done pulse.
- A fresh start after deassert completes normally.
- Illegal code 0x2 (a=3, b=4) -> done after 1 cycle, result=0, branch_taken=0.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Operation codes, execute-stage state type and helper shared
//                by the ALU controller and the iterative execute ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b1010;
    localparam logic [3:0] OP_ADD = 4'b1011;
    localparam logic [3:0] OP_SLT = 4'b1100;
    localparam logic [3:0] OP_BEQ = 4'b1000;
    localparam logic [3:0] OP_BNE = 4'b1101;
    localparam logic [3:0] OP_BLT = 4'b1110;
    localparam logic [3:0] OP_BGE = 4'b1111;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } exec_state_t;

    // True for the two ops that go through the iterative shifter
    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_iter_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_iter_shifter
//  Description : Iterative logical shifter. Holds the operand and the number
//                of bit positions still to shift; each enabled cycle shifts by
//                min(SHIFT_STEP, remaining) with zero fill.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_iter_shifter #(
    parameter int DATA_W     = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic                      shift_left,
    input  logic [DATA_W-1:0]         load_data,
    input  logic [$clog2(DATA_W)-1:0] load_amt,
    input  logic                      step_en,
    output logic [DATA_W-1:0]         step_data,
    output logic                      last_step
);

    localparam int SH_W   = $clog2(DATA_W);
    // One extra bit so SHIFT_STEP == DATA_W is representable
    localparam int STEP_W = SH_W + 1;
    localparam logic [STEP_W-1:0] c_step_amt = STEP_W'(SHIFT_STEP);

    logic [DATA_W-1:0] r_data;
    logic [SH_W-1:0]   r_rem;
    logic              r_left;

    logic [STEP_W-1:0] w_rem_ext;
    logic [STEP_W-1:0] w_amt;

    // Step amount is the full step unless fewer positions remain
    always_comb begin
        w_rem_ext = {1'b0, r_rem};
        last_step = (w_rem_ext <= c_step_amt);
        w_amt     = last_step ? w_rem_ext : c_step_amt;
        step_data = r_left ? (r_data << w_amt) : (r_data >> w_amt);
    end

    // Operand/count latch on load, advance by one step while enabled
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
            r_rem  <= '0;
            r_left <= 1'b0;
        end else if (load) begin
            r_data <= load_data;
            r_rem  <= load_amt;
            r_left <= shift_left;
        end else if (step_en) begin
            r_data <= step_data;
            // A non-final step always removes a full SHIFT_STEP (< DATA_W)
            r_rem  <= last_step ? '0 : (r_rem - SH_W'(SHIFT_STEP));
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_iter_exec.sv
`default_nettype none
// ============================================================================
//  Module      : alu_iter_exec
//  Description : Execute-stage ALU. Logic, add/sub, compare and branch ops
//                complete in one cycle; SLL/SRL run on an iterative shifter
//                and stall upstream through busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_iter_exec
    import alu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        operation,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              branch_taken
);

    localparam int SH_W = $clog2(DATA_W);

    exec_state_t       r_state;
    exec_state_t       w_next_state;

    logic [DATA_W-1:0] r_result;
    logic              r_branch_taken;
    logic              r_done;

    logic [DATA_W-1:0] w_alu_result;
    logic              w_alu_branch;
    logic              w_signed_lt;
    logic              w_is_shift;
    logic [SH_W-1:0]   w_shamt;
    logic              w_load;
    logic              w_accept_single;
    logic              w_finish_shift;
    logic [DATA_W-1:0] w_step_data;
    logic              w_last_step;

    assign w_is_shift = is_shift_op(operation);
    assign w_shamt    = src_b[SH_W-1:0];

    alu_iter_shifter #(
        .DATA_W     (DATA_W),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shifter (
        .clk        (clk),
        .reset      (reset),
        .load       (w_load),
        .shift_left (operation == OP_SLL),
        .load_data  (src_a),
        .load_amt   (w_shamt),
        .step_en    (r_state == SHIFT),
        .step_data  (w_step_data),
        .last_step  (w_last_step)
    );

    // Single-cycle datapath: result and branch decision from the op code
    always_comb begin
        w_alu_result = '0;
        w_alu_branch = 1'b0;
        w_signed_lt  = ($signed(src_a) < $signed(src_b));
        unique case (operation)
            OP_AND:  w_alu_result = src_a & src_b;
            OP_OR:   w_alu_result = src_a | src_b;
            OP_XOR:  w_alu_result = src_a ^ src_b;
            OP_ADD:  w_alu_result = src_a + src_b;
            OP_SUB:  w_alu_result = src_a - src_b;
            OP_SLT:  w_alu_result = {{(DATA_W-1){1'b0}}, w_signed_lt};
            OP_BEQ:  w_alu_branch = (src_a == src_b);
            OP_BNE:  w_alu_branch = (src_a != src_b);
            OP_BLT:  w_alu_branch = w_signed_lt;
            OP_BGE:  w_alu_branch = !w_signed_lt;
            default: begin
                w_alu_result = '0;
                w_alu_branch = 1'b0;
            end
        endcase
    end

    // FSM next state plus the accept/finish strobes used by the output regs
    always_comb begin
        w_next_state    = r_state;
        w_load          = 1'b0;
        w_accept_single = 1'b0;
        w_finish_shift  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_load = w_is_shift;
                    // Zero-distance shifts complete like any 1-cycle op
                    if (w_is_shift && (w_shamt != '0)) begin
                        w_next_state = SHIFT;
                    end else begin
                        w_accept_single = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (w_last_step) begin
                    w_finish_shift = 1'b1;
                    w_next_state   = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Output registers: capture on completion, done pulses for one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result       <= '0;
            r_branch_taken <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept_single) begin
                r_result       <= w_is_shift ? src_a : w_alu_result;
                r_branch_taken <= w_alu_branch;
                r_done         <= 1'b1;
            end else if (w_finish_shift) begin
                r_result       <= w_step_data;
                r_branch_taken <= 1'b0;
                r_done         <= 1'b1;
            end
        end
    end

    assign busy         = (r_state == SHIFT);
    assign done         = r_done;
    assign result       = r_result;
    assign branch_taken = r_branch_taken;

endmodule
`default_nettype wire

// File: tb/tb_alu_iter_exec.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_iter_exec
//  Description : Directed self-checking bench for alu_iter_exec, with one
//                instance at SHIFT_STEP=1 and one at SHIFT_STEP=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_iter_exec;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        start4;
    logic [3:0]  operation;
    logic [31:0] src_a;
    logic [31:0] src_b;

    logic        busy,  busy4;
    logic        done,  done4;
    logic [31:0] result, result4;
    logic        branch_taken, branch_taken4;

    int checks   = 0;
    int failures = 0;
    int n_busy;
    int n_edges;
    int n_done_busy;

    always #5 clk = ~clk;

    alu_iter_exec #(.DATA_W(32), .SHIFT_STEP(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .operation    (operation),
        .src_a        (src_a),
        .src_b        (src_b),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .branch_taken (branch_taken)
    );

    alu_iter_exec #(.DATA_W(32), .SHIFT_STEP(4)) dut4 (
        .clk          (clk),
        .reset        (reset),
        .start        (start4),
        .operation    (operation),
        .src_a        (src_a),
        .src_b        (src_b),
        .busy         (busy4),
        .done         (done4),
        .result       (result4),
        .branch_taken (branch_taken4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present an op at the falling edge, then sample 1 after the next rise
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start     = 1'b1;
        operation = op;
        src_a     = a;
        src_b     = b;
        @(posedge clk);
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b1;
        start4    = 1'b0;
        operation = OP_ADD;
        src_a     = 32'd1;
        src_b     = 32'd1;

        // Reset with start held high
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_busy",   {31'd0, busy},         32'd0);
            chk("rst_done",   {31'd0, done},         32'd0);
            chk("rst_result", result,                32'd0);
            chk("rst_branch", {31'd0, branch_taken}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        // Back-to-back single-cycle ops
        issue(OP_ADD, 32'h7FFF_FFFF, 32'd1);
        chk("add_done",   {31'd0, done}, 32'd1);
        chk("add_result", result,        32'h8000_0000);
        issue(OP_SUB, 32'd0, 32'd1);
        chk("sub_done",   {31'd0, done}, 32'd1);
        chk("sub_result", result,        32'hFFFF_FFFF);
        issue(OP_SLT, 32'hFFFF_FFFF, 32'd1);
        chk("slt_result", result,        32'd1);
        issue(OP_BLT, 32'hFFFF_FFFF, 32'd1);
        chk("blt_result", result,                32'd0);
        chk("blt_branch", {31'd0, branch_taken}, 32'd1);
        issue(OP_XOR, 32'hF0F0_00FF, 32'h0FF0_0F0F);
        chk("xor_result", result,                32'hFF00_0FF0);
        chk("xor_branch", {31'd0, branch_taken}, 32'd0);
        issue(OP_BGE, 32'd5, 32'd5);
        chk("bge_branch", {31'd0, branch_taken}, 32'd1);

        // Idle cycle: done drops, outputs hold
        @(negedge clk);
        start = 1'b0;
        tick();
        chk("idle_done",   {31'd0, done},         32'd0);
        chk("idle_branch", {31'd0, branch_taken}, 32'd1);

        issue(OP_BNE, 32'd5, 32'd5);
        chk("bne_branch", {31'd0, branch_taken}, 32'd0);
        chk("bne_done",   {31'd0, done},         32'd1);

        // SLL by 31 at one bit per cycle, with an ADD offered during the shift
        issue(OP_SLL, 32'h0000_0001, 32'd31);
        n_busy      = 0;
        n_edges     = 1;
        n_done_busy = 0;
        if (busy) n_busy++;
        @(negedge clk);
        operation = OP_ADD;
        src_a     = 32'd1;
        src_b     = 32'd1;
        while (busy && n_edges < 40) begin
            tick();
            n_edges++;
            if (busy) n_busy++;
            if (busy && done) n_done_busy++;
        end
        chk("sll31_busy_cycles", n_busy,        32'd31);
        chk("sll31_latency",     n_edges,       32'd32);
        chk("sll31_done",        {31'd0, done}, 32'd1);
        chk("sll31_result",      result,        32'h8000_0000);
        chk("sll31_early_done",  n_done_busy,   32'd0);
        @(negedge clk);
        start = 1'b0;

        // Zero-distance shift completes in one cycle without busy
        issue(OP_SRL, 32'h8000_0000, 32'd0);
        chk("srl0_done",   {31'd0, done}, 32'd1);
        chk("srl0_busy",   {31'd0, busy}, 32'd0);
        chk("srl0_result", result,        32'h8000_0000);
        @(negedge clk);
        start = 1'b0;

        // Four bits per cycle: SRL by 5 takes two shift cycles
        @(negedge clk);
        start4    = 1'b1;
        operation = OP_SRL;
        src_a     = 32'hF000_0000;
        src_b     = 32'd5;
        tick();
        chk("srl5_busy1", {31'd0, busy4}, 32'd1);
        @(negedge clk);
        start4 = 1'b0;
        tick();
        chk("srl5_busy2", {31'd0, busy4}, 32'd1);
        chk("srl5_nodone", {31'd0, done4}, 32'd0);
        tick();
        chk("srl5_done",   {31'd0, done4}, 32'd1);
        chk("srl5_busy3",  {31'd0, busy4}, 32'd0);
        chk("srl5_result", result4,        32'h0780_0000);

        // Reset during the third busy cycle aborts the shift
        issue(OP_SLL, 32'h0000_00FF, 32'd8);
        @(negedge clk);
        start = 1'b0;
        tick();
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("abort_busy",   {31'd0, busy},         32'd0);
        chk("abort_done",   {31'd0, done},         32'd0);
        chk("abort_result", result,                32'd0);
        chk("abort_branch", {31'd0, branch_taken}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("post_abort_done", {31'd0, done}, 32'd0);

        // Fresh shift after reset completes normally
        issue(OP_SLL, 32'h0000_00FF, 32'd8);
        @(negedge clk);
        start   = 1'b0;
        n_edges = 1;
        while (!done && n_edges < 20) begin
            tick();
            n_edges++;
        end
        chk("sll8_latency", n_edges, 32'd9);
        chk("sll8_result",  result,  32'h0000_FF00);

        // Illegal code, then a taken branch, then illegal again
        issue(4'b0010, 32'd3, 32'd4);
        chk("ill_done",   {31'd0, done},         32'd1);
        chk("ill_result", result,                32'd0);
        chk("ill_branch", {31'd0, branch_taken}, 32'd0);
        issue(OP_BEQ, 32'd3, 32'd3);
        chk("beq_branch", {31'd0, branch_taken}, 32'd1);
        issue(4'b0010, 32'd3, 32'd4);
        chk("ill2_branch", {31'd0, branch_taken}, 32'd0);
        chk("ill2_done",   {31'd0, done},         32'd1);

        @(negedge clk);
        start = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
